// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte stream in, instruction RAM write port out
interface im_loader_if #(
    parameter int AW = 11
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_din;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_din
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_din
    );
endinterface

// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-stream loader filling the instruction RAM with big-endian words
// Optional trailing XOR checksum byte: define IM_LOADER_CHECKSUM_EN.
module im_loader #(
    parameter int          DEPTH     = 2048,
    parameter int          AW        = 11,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    im_loader_if.slave  bus,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [31:0] load_end_addr
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    state_t      state, state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] word_count;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] shift;
    logic        xfer;
    logic        start_ok;
    logic [15:0] len_in;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign start_ok = load_start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign len_in   = {len_hi, bus.byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_in == 16'd0)                     state_nxt = S_TAIL;
                    else if ({1'b0, len_in} > DEPTH_LIM)     state_nxt = S_ERR;
                    else                                     state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (word_idx + 16'd1 < word_count) state_nxt = S_DATA;
                else                               state_nxt = S_TAIL;
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_nxt = (csum == bus.byte_data) ? S_DONE : S_ERR;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi        <= 8'd0;
            word_count    <= 16'd0;
            word_idx      <= 16'd0;
            byte_cnt      <= 2'd0;
            shift         <= 32'd0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            load_end_addr <= 32'd0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum          <= 8'd0;
`endif
        end else begin
            if (start_ok) begin
                load_done  <= 1'b0;
                load_err   <= 1'b0;
                word_count <= 16'd0;
                word_idx   <= 16'd0;
                byte_cnt   <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
                csum       <= 8'd0;
`endif
            end
`ifdef IM_LOADER_CHECKSUM_EN
            if (xfer && state != S_CSUM) csum <= csum ^ bus.byte_data;
`endif
            case (state)
                S_LEN_HI: if (xfer) len_hi <= bus.byte_data;
                S_LEN_LO: if (xfer) word_count <= len_in;
                S_DATA: begin
                    if (xfer) begin
                        shift    <= {shift[23:0], bus.byte_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WRITE:  word_idx <= word_idx + 16'd1;
                default: ;
            endcase
            // On the count==0 path word_count still holds the 0 cleared at load_start.
            if (state_nxt == S_DONE && state != S_DONE) begin
                load_done     <= 1'b1;
                load_end_addr <= BASE_ADDR + {14'd0, word_count, 2'b00};
            end
            if (state_nxt == S_ERR && state != S_ERR) load_err <= 1'b1;
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    assign bus.byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                            (state == S_DATA)   || (state == S_CSUM);
`else
    assign bus.byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                            (state == S_DATA);
`endif
    assign cpu_hold    = !(state == S_IDLE || state == S_DONE || state == S_ERR);
    assign bus.im_we   = (state == S_WRITE);
    assign bus.im_addr = word_idx[AW-1:0];
    assign bus.im_din  = shift;
endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - table-driven loads with a write scoreboard for im_loader
module tb_im_loader;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
`ifdef IM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        cpu_hold, load_done, load_err;
    logic [31:0] load_end_addr;

    im_loader_if #(.AW(AW)) bus();

    im_loader #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .bus(bus.slave),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
        .load_end_addr(load_end_addr)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    typedef struct {
        int          n;
        logic [7:0]  b [14];
        bit          gap;
        bit          exp_err;
        logic [31:0] exp_end;
        int          exp_writes;
    } vec_t;

    wr_t sb[$];
    int  n_pass = 0, n_total = 0, wr_cnt = 0, cyc = 0, st_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every write seen on the RAM port must match the next expected word.
    wr_t mon_e;
    always @(negedge clk) begin
        if (rst_n && bus.im_we) begin
            wr_cnt++;
            chk("ready_low_in_write", {31'd0, bus.byte_ready}, 32'd0);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr %h data %h with no write pending", bus.im_addr, bus.im_din);
            end else begin
                mon_e = sb.pop_front();
                chk("write_addr", {21'd0, bus.im_addr}, {21'd0, mon_e.addr});
                chk("write_data", bus.im_din, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        t = 0;
        while (!bus.byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_total++;
            $display("FAIL send_timeout: byte_ready stayed 0 for byte %h", b);
        end
        @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
        st_cyc = cyc;
        chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        chk("ready_in_len_hi", {31'd0, bus.byte_ready}, 32'd1);
        chk("done_cleared", {31'd0, load_done}, 32'd0);
        chk("err_cleared", {31'd0, load_err}, 32'd0);
    endtask

    task automatic run_stream(input bq_t s, input bit gap, input bit bad_csum, input bit exp_err,
                              input logic [31:0] exp_end, input int exp_writes, input string tag);
        int          cnt, w0, t, exp_cyc;
        logic [7:0]  x;
        wr_t         e;
        bq_t         tx;
        tx  = s;
        cnt = int'({s[0], s[1]});
        x   = 8'd0;
        foreach (s[i]) x ^= s[i];
        if (cnt <= DEPTH) begin
            for (int i = 0; i < cnt; i++) begin
                e.addr = AW'(i);
                e.data = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
                sb.push_back(e);
            end
`ifdef IM_LOADER_CHECKSUM_EN
            if (bad_csum) tx.push_back((x == 8'h00) ? 8'hFF : 8'h00);
            else          tx.push_back(x);
`endif
        end
        exp_cyc = (cnt > DEPTH) ? 2 : 2 + 5 * cnt + CS;
        w0 = wr_cnt;
        pulse_start();
        foreach (tx[i]) send_byte(tx[i], gap);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        t = 0;
        while (!load_done && !load_err && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!gap) chk({tag, "_cycles"}, cyc - st_cyc, exp_cyc);
        chk({tag, "_done"}, {31'd0, load_done}, {31'd0, !exp_err});
        chk({tag, "_err"}, {31'd0, load_err}, {31'd0, exp_err});
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        if (!exp_err) chk({tag, "_end_addr"}, load_end_addr, exp_end);
        chk({tag, "_writes"}, wr_cnt - w0, exp_writes);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        sb.delete();
    endtask

    vec_t vt[5];
    bq_t  s;

    initial begin
        vt[0] = '{10, '{8'h00,8'h02,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h00,8'h00,8'h00,8'h00}, 1'b0, 1'b0, 32'h0000_3008, 2};
        vt[1] = '{2,  '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b0, 1'b0, 32'h0000_3000, 0};
        vt[2] = '{2,  '{8'h08,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b0, 1'b1, 32'h0000_0000, 0};
        vt[3] = '{6,  '{8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b1, 1'b0, 32'h0000_3004, 1};
        vt[4] = '{14, '{8'h00,8'h03,8'h01,8'h02,8'h03,8'h04,8'hFF,8'h00,8'hFF,8'h00,8'h80,8'h00,8'h00,8'h01}, 1'b0, 1'b0, 32'h0000_300C, 3};

        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        chk("rst_we", {31'd0, bus.im_we}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_end_addr", load_end_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            s = {};
            for (int j = 0; j < vt[i].n; j++) s.push_back(vt[i].b[j]);
            run_stream(s, vt[i].gap, 1'b0, vt[i].exp_err, vt[i].exp_end, vt[i].exp_writes, $sformatf("vec%0d", i));
        end

        // Reset after byte 2 of word 0, then a clean reload must start at address 0.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("midrst_ready", {31'd0, bus.byte_ready}, 32'd0);
        chk("midrst_we", {31'd0, bus.im_we}, 32'd0);
        chk("midrst_addr", {21'd0, bus.im_addr}, 32'd0);
        chk("midrst_din", bus.im_din, 32'd0);
        chk("midrst_done", {31'd0, load_done}, 32'd0);
        chk("midrst_err", {31'd0, load_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(s, 1'b0, 1'b0, 1'b0, 32'h0000_3004, 1, "reload");

`ifdef IM_LOADER_CHECKSUM_EN
        run_stream(s, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1, "bad_csum");
`endif

        // Largest legal load: every address up to DEPTH-1 gets written.
        s = '{8'h08, 8'h00};
        for (int i = 0; i < 4 * DEPTH; i++) s.push_back(8'((i * 7 + 3) ^ (i >> 8)));
        run_stream(s, 1'b0, 1'b0, 1'b0, 32'h0000_5000, DEPTH, "full");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
